// File: rtl/sbp_pkg.sv
// Shared types and helpers for the SBP lookup pipeline stages.
// node_t describes one trie node at the default key/stage/location widths.
package sbp_pkg;

  localparam int SBP_KEY_BITS      = 32;
  localparam int SBP_STAGE_BITS    = 6;
  localparam int SBP_LOCATION_BITS = 11;
  localparam int SBP_POS_BITS      = $clog2(SBP_KEY_BITS) + 1;
  localparam int MAX_KEY_BITS      = 128;

  // Stage id 0 never answers a lookup; it marks a finished walk.
  localparam int STAGE_TERMINATED  = 0;

  typedef struct packed {
    logic [SBP_KEY_BITS-1:0]      prefix;
    logic [SBP_POS_BITS-1:0]      prefix_len;
    logic [SBP_STAGE_BITS-1:0]    child_stage;
    logic [SBP_LOCATION_BITS-1:0] child_loc;
    logic                         has_left;
    logic                         has_right;
    logic                         is_result;
  } node_t;

  // Mask selecting the top 'len' bits of a key_bits-wide key (LSB aligned).
  function automatic logic [MAX_KEY_BITS-1:0] prefix_mask(input int key_bits, input int len);
    logic [MAX_KEY_BITS-1:0] mask;
    mask = {MAX_KEY_BITS{1'b0}};
    for (int i = 0; i < MAX_KEY_BITS; i++) begin
      if ((i < key_bits) && ((i + len) >= key_bits)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/sbp_stage_ram.sv
// Node memory for one lookup stage: simple dual port, registered read,
// a write to the address being read in the same cycle is returned directly.
module sbp_stage_ram
  import sbp_pkg::*;
#(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_r [DEPTH];

  // Write port plus write-first registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/sbp_lookup_stage_rw.sv
// One stage of the SBP trie walk: reads the node addressed by the beat,
// compares the prefix, records a result and routes the beat to the child.
module sbp_lookup_stage_rw
  import sbp_pkg::*;
#(
  parameter  int STAGE_ID      = 1,
  parameter  int STAGE_BITS    = 6,
  parameter  int LOCATION_BITS = 11,
  parameter  int KEY_BITS      = 32,
  localparam int POS_BITS      = $clog2(KEY_BITS) + 1,
  localparam int RESULT_BITS   = STAGE_BITS + LOCATION_BITS,
  localparam int NODE_BITS     = KEY_BITS + POS_BITS + STAGE_BITS + LOCATION_BITS + 3
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     valid_i,
  input  logic [KEY_BITS-1:0]      key_i,
  input  logic [POS_BITS-1:0]      bit_pos_i,
  input  logic [STAGE_BITS-1:0]    stage_id_i,
  input  logic [LOCATION_BITS-1:0] location_i,
  input  logic [RESULT_BITS-1:0]   result_i,

  output logic                     valid_o,
  output logic [KEY_BITS-1:0]      key_o,
  output logic [POS_BITS-1:0]      bit_pos_o,
  output logic [STAGE_BITS-1:0]    stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,

  input  logic                     upd_valid_i,
  input  logic [LOCATION_BITS-1:0] upd_addr_i,
  input  logic [NODE_BITS-1:0]     upd_data_i,

  output logic [31:0]              hit_count_o
);

  // Same field layout as sbp_pkg::node_t, sized by this instance's parameters.
  typedef struct packed {
    logic [KEY_BITS-1:0]      prefix;
    logic [POS_BITS-1:0]      prefix_len;
    logic [STAGE_BITS-1:0]    child_stage;
    logic [LOCATION_BITS-1:0] child_loc;
    logic                     has_left;
    logic                     has_right;
    logic                     is_result;
  } stage_node_t;

  localparam logic [STAGE_BITS-1:0]    MY_STAGE   = STAGE_BITS'(STAGE_ID);
  localparam logic [STAGE_BITS-1:0]    TERM_STAGE = STAGE_BITS'(STAGE_TERMINATED);
  localparam logic [POS_BITS-1:0]      KEY_LEN    = POS_BITS'(KEY_BITS);
  localparam logic [POS_BITS-1:0]      POS_ONE    = {{(POS_BITS-1){1'b0}}, 1'b1};
  localparam logic [LOCATION_BITS-1:0] LOC_ONE    = {{(LOCATION_BITS-1){1'b0}}, 1'b1};
  localparam logic [KEY_BITS-1:0]      KEY_MSB    = {1'b1, {(KEY_BITS-1){1'b0}}};

  logic                     s1_valid_r;
  logic [KEY_BITS-1:0]      s1_key_r;
  logic [POS_BITS-1:0]      s1_bit_pos_r;
  logic [STAGE_BITS-1:0]    s1_stage_r;
  logic [LOCATION_BITS-1:0] s1_loc_r;
  logic [RESULT_BITS-1:0]   s1_result_r;

  logic [NODE_BITS-1:0]     ram_rdata_s;
  stage_node_t              node_s;
  logic [KEY_BITS-1:0]      mask_s;
  logic                     sel_s;
  logic                     match_s;
  logic                     right_s;
  logic                     hit_s;

  logic                     nxt_valid_s;
  logic [KEY_BITS-1:0]      nxt_key_s;
  logic [POS_BITS-1:0]      nxt_bit_pos_s;
  logic [STAGE_BITS-1:0]    nxt_stage_s;
  logic [LOCATION_BITS-1:0] nxt_loc_s;
  logic [RESULT_BITS-1:0]   nxt_result_s;

  sbp_stage_ram #(
    .ADDR_BITS (LOCATION_BITS),
    .DATA_BITS (NODE_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (upd_valid_i),
    .wr_addr (upd_addr_i),
    .wr_data (upd_data_i),
    .rd_addr (location_i),
    .rd_data (ram_rdata_s)
  );

  // Stage-1 beat register, aligned with the node read issued this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= valid_i;
    end
    s1_key_r     <= key_i;
    s1_bit_pos_r <= bit_pos_i;
    s1_stage_r   <= stage_id_i;
    s1_loc_r     <= location_i;
    s1_result_r  <= result_i;
  end

  assign node_s  = stage_node_t'(ram_rdata_s);
  assign sel_s   = s1_valid_r && (s1_stage_r == MY_STAGE);
  // A bit position at or beyond the key width shifts the probe out: goes left.
  assign right_s = |(s1_key_r & (KEY_MSB >> s1_bit_pos_r));

  // Prefix compare of the looked-up node against the beat key.
  always_comb begin
    mask_s = KEY_BITS'(prefix_mask(KEY_BITS, 32'(node_s.prefix_len)));
    if (node_s.prefix_len > KEY_LEN) begin
      match_s = 1'b0;
    end else begin
      match_s = (((s1_key_r ^ node_s.prefix) & mask_s) == {KEY_BITS{1'b0}});
    end
  end

  // Stage-2 output values: routing, result capture and pass-through.
  always_comb begin
    nxt_valid_s   = 1'b0;
    nxt_key_s     = {KEY_BITS{1'b0}};
    nxt_bit_pos_s = {POS_BITS{1'b0}};
    nxt_stage_s   = {STAGE_BITS{1'b0}};
    nxt_loc_s     = {LOCATION_BITS{1'b0}};
    nxt_result_s  = {RESULT_BITS{1'b0}};
    hit_s         = 1'b0;
    if (s1_valid_r) begin
      nxt_valid_s = 1'b1;
      nxt_key_s   = s1_key_r;
      if (s1_bit_pos_r >= KEY_LEN) begin
        nxt_bit_pos_s = KEY_LEN;
      end else begin
        nxt_bit_pos_s = s1_bit_pos_r + POS_ONE;
      end
      if (sel_s) begin
        hit_s = match_s;
        if (right_s && node_s.has_right) begin
          nxt_stage_s = node_s.child_stage;
          nxt_loc_s   = node_s.child_loc + LOC_ONE;
        end else if (!right_s && node_s.has_left) begin
          nxt_stage_s = node_s.child_stage;
          nxt_loc_s   = node_s.child_loc;
        end else begin
          nxt_stage_s = TERM_STAGE;
          nxt_loc_s   = {LOCATION_BITS{1'b0}};
        end
        if (match_s && node_s.is_result) begin
          nxt_result_s = {MY_STAGE, s1_loc_r};
        end else begin
          nxt_result_s = s1_result_r;
        end
      end else begin
        nxt_stage_s  = s1_stage_r;
        nxt_loc_s    = s1_loc_r;
        nxt_result_s = s1_result_r;
      end
    end else begin
      nxt_valid_s = 1'b0;
    end
  end

  // Output register and saturating hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      key_o       <= {KEY_BITS{1'b0}};
      bit_pos_o   <= {POS_BITS{1'b0}};
      stage_id_o  <= {STAGE_BITS{1'b0}};
      location_o  <= {LOCATION_BITS{1'b0}};
      result_o    <= {RESULT_BITS{1'b0}};
      hit_count_o <= 32'd0;
    end else begin
      valid_o    <= nxt_valid_s;
      key_o      <= nxt_key_s;
      bit_pos_o  <= nxt_bit_pos_s;
      stage_id_o <= nxt_stage_s;
      location_o <= nxt_loc_s;
      result_o   <= nxt_result_s;
      if (hit_s && (hit_count_o != 32'hFFFF_FFFF)) begin
        hit_count_o <= hit_count_o + 32'd1;
      end else begin
        hit_count_o <= hit_count_o;
      end
    end
  end

endmodule

// File: tb/tb_sbp_lookup_stage_rw.sv
// Randomized bench for sbp_lookup_stage_rw: an IPv4 (32-bit) and an IPv6
// (128-bit) instance run side by side against a behavioural lookup model.
module tb_sbp_lookup_stage_rw;

  typedef struct {
    logic         v;
    logic [127:0] key;
    int           bp;
    int           st;
    int           loc;
    int           res;
  } beat_t;

  typedef struct {
    logic [127:0] prefix;
    int           len;
    int           cs;
    int           cl;
    logic         l;
    logic         r;
    logic         res;
  } mnode_t;

  typedef struct {
    logic         v;
    logic [127:0] key;
    int           bp;
    int           st;
    int           loc;
    int           res;
    logic [31:0]  hits;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  beat_t        b_in   [2];
  mnode_t       n_in   [2];
  logic         upd_v  [2];
  int           upd_a  [2];
  mnode_t       mem_m  [2][2048];
  logic [31:0]  hits_m [2];
  exp_t         exp_prev [2];
  logic [127:0] obs [2][7];

  logic         valid_o0, valid_o1;
  logic [31:0]  key_o0;
  logic [127:0] key_o1;
  logic [5:0]   bp_o0;
  logic [7:0]   bp_o1;
  logic [5:0]   st_o0, st_o1;
  logic [10:0]  loc_o0, loc_o1;
  logic [16:0]  res_o0, res_o1;
  logic [31:0]  hc_o0, hc_o1;

  sbp_lookup_stage_rw #(.STAGE_ID(1), .STAGE_BITS(6), .LOCATION_BITS(11), .KEY_BITS(32)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (b_in[0].v),
    .key_i       (32'(b_in[0].key)),
    .bit_pos_i   (6'(b_in[0].bp)),
    .stage_id_i  (6'(b_in[0].st)),
    .location_i  (11'(b_in[0].loc)),
    .result_i    (17'(b_in[0].res)),
    .valid_o     (valid_o0),
    .key_o       (key_o0),
    .bit_pos_o   (bp_o0),
    .stage_id_o  (st_o0),
    .location_o  (loc_o0),
    .result_o    (res_o0),
    .upd_valid_i (upd_v[0]),
    .upd_addr_i  (11'(upd_a[0])),
    .upd_data_i  ({32'(n_in[0].prefix), 6'(n_in[0].len), 6'(n_in[0].cs), 11'(n_in[0].cl),
                   n_in[0].l, n_in[0].r, n_in[0].res}),
    .hit_count_o (hc_o0)
  );

  sbp_lookup_stage_rw #(.STAGE_ID(2), .STAGE_BITS(6), .LOCATION_BITS(11), .KEY_BITS(128)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (b_in[1].v),
    .key_i       (b_in[1].key),
    .bit_pos_i   (8'(b_in[1].bp)),
    .stage_id_i  (6'(b_in[1].st)),
    .location_i  (11'(b_in[1].loc)),
    .result_i    (17'(b_in[1].res)),
    .valid_o     (valid_o1),
    .key_o       (key_o1),
    .bit_pos_o   (bp_o1),
    .stage_id_o  (st_o1),
    .location_o  (loc_o1),
    .result_o    (res_o1),
    .upd_valid_i (upd_v[1]),
    .upd_addr_i  (11'(upd_a[1])),
    .upd_data_i  ({n_in[1].prefix, 8'(n_in[1].len), 6'(n_in[1].cs), 11'(n_in[1].cl),
                   n_in[1].l, n_in[1].r, n_in[1].res}),
    .hit_count_o (hc_o1)
  );

  assign obs[0][0] = 128'(valid_o0);
  assign obs[0][1] = 128'(key_o0);
  assign obs[0][2] = 128'(bp_o0);
  assign obs[0][3] = 128'(st_o0);
  assign obs[0][4] = 128'(loc_o0);
  assign obs[0][5] = 128'(res_o0);
  assign obs[0][6] = 128'(hc_o0);
  assign obs[1][0] = 128'(valid_o1);
  assign obs[1][1] = key_o1;
  assign obs[1][2] = 128'(bp_o1);
  assign obs[1][3] = 128'(st_o1);
  assign obs[1][4] = 128'(loc_o1);
  assign obs[1][5] = 128'(res_o1);
  assign obs[1][6] = 128'(hc_o1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic string fname(int f);
    case (f)
      0: return "valid";
      1: return "key";
      2: return "bit_pos";
      3: return "stage_id";
      4: return "location";
      5: return "result";
      default: return "hit_count";
    endcase
  endfunction

  function automatic int kbits(int d);
    return (d == 0) ? 32 : 128;
  endfunction

  function automatic int sid(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic exp_t idle_exp(logic [31:0] h);
    exp_t e;
    e = '{default: 0};
    e.hits = h;
    return e;
  endfunction

  // Lookup semantics: top-len prefix compare, MSB-first direction bit, child routing.
  function automatic exp_t model(int d, beat_t b);
    exp_t   e;
    mnode_t n;
    int     kb;
    bit     match;
    bit     right;
    kb = kbits(d);
    e  = idle_exp(hits_m[d]);
    if (!b.v) return e;
    e.v   = 1'b1;
    e.key = b.key;
    e.bp  = (b.bp >= kb) ? kb : b.bp + 1;
    e.st  = b.st;
    e.loc = b.loc;
    e.res = b.res;
    if (b.st == sid(d)) begin
      n = mem_m[d][b.loc];
      if (n.len > kb) match = 1'b0;
      else if (n.len == 0) match = 1'b1;
      else match = ((b.key >> (kb - n.len)) == (n.prefix >> (kb - n.len)));
      right = (b.bp < kb) ? b.key[kb-1-b.bp] : 1'b0;
      if (right && n.r) begin
        e.st  = n.cs;
        e.loc = (n.cl + 1) % 2048;
      end else if (!right && n.l) begin
        e.st  = n.cs;
        e.loc = n.cl;
      end else begin
        e.st  = 0;
        e.loc = 0;
      end
      if (match && n.res) e.res = (sid(d) << 11) | b.loc;
      if (match && (hits_m[d] != 32'hFFFF_FFFF)) hits_m[d] = hits_m[d] + 32'd1;
      e.hits = hits_m[d];
    end
    return e;
  endfunction

  function automatic logic [127:0] rnd_key(int d);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (d == 0) k = k & 128'hFFFF_FFFF;
    return k;
  endfunction

  function automatic mnode_t mk(logic [127:0] p, int len, int cs, int cl, logic l, logic r, logic res);
    mnode_t n;
    n.prefix = p; n.len = len; n.cs = cs; n.cl = cl; n.l = l; n.r = r; n.res = res;
    return n;
  endfunction

  function automatic mnode_t rnd_node(int d);
    int cl;
    cl = ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(0, 2047));
    return mk(rnd_key(d), $urandom_range(0, kbits(d) + 2), $urandom_range(0, 63), cl,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  // One clock: model this cycle's beats, then compare the beat issued a cycle earlier.
  task automatic tick();
    exp_t e [2];
    for (int d = 0; d < 2; d++) begin
      if (upd_v[d]) mem_m[d][upd_a[d]] = n_in[d];
      if (rst) begin
        hits_m[d] = 32'd0;
        e[d] = idle_exp(32'd0);
      end else begin
        e[d] = model(d, b_in[d]);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [127:0] ex [7];
      if (rst) exp_prev[d] = idle_exp(32'd0);
      ex[0] = 128'(exp_prev[d].v);
      ex[1] = exp_prev[d].key;
      ex[2] = 128'(exp_prev[d].bp);
      ex[3] = 128'(exp_prev[d].st);
      ex[4] = 128'(exp_prev[d].loc);
      ex[5] = 128'(exp_prev[d].res);
      ex[6] = 128'(exp_prev[d].hits);
      for (int f = 0; f < 7; f++) check($sformatf("d%0d.%s", d, fname(f)), obs[d][f], ex[f]);
      exp_prev[d] = e[d];
      b_in[d].v = 1'b0;
      upd_v[d]  = 1'b0;
    end
  endtask

  task automatic beat(int d, logic [127:0] key, int bp, int st, int loc, int res);
    b_in[d] = '{v: 1'b1, key: key, bp: bp, st: st, loc: loc, res: res};
  endtask

  task automatic wr(int d, int addr, mnode_t n);
    upd_v[d] = 1'b1;
    upd_a[d] = addr;
    n_in[d]  = n;
  endtask

  initial begin
    logic [127:0] p;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      b_in[d]     = '{v: 1'b0, key: 128'd0, bp: 0, st: 0, loc: 0, res: 0};
      n_in[d]     = mk(128'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      upd_v[d]    = 1'b0;
      upd_a[d]    = 0;
      hits_m[d]   = 32'd0;
      exp_prev[d] = idle_exp(32'd0);
      for (int a = 0; a < 2048; a++) mem_m[d][a] = mk(128'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    tick(); tick(); tick();
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int d = 0; d < 2; d++) wr(d, a, rnd_node(d));
      tick();
    end

    // Hit and right turn through node@5.
    wr(0, 5, mk(128'h0A00_0000, 8, 2, 40, 1'b1, 1'b1, 1'b1));
    tick();
    beat(0, 128'h0A80_0000, 8, 1, 5, 0);
    tick(); tick();
    check("n5_hit.stage", obs[0][3], 128'd2);
    check("n5_hit.loc", obs[0][4], 128'd41);
    check("n5_hit.result", obs[0][5], 128'h805);
    check("n5_hit.bit_pos", obs[0][2], 128'd9);
    check("n5_hit.hits", obs[0][6], 128'd1);

    // Miss, left turn, result passes through.
    beat(0, 128'h0B00_0000, 8, 1, 5, 'h123);
    tick(); tick();
    check("n5_miss.loc", obs[0][4], 128'd40);
    check("n5_miss.result", obs[0][5], 128'h123);
    check("n5_miss.hits", obs[0][6], 128'd1);

    // Missing right child terminates; foreign stage id passes through.
    wr(0, 6, mk(128'd0, 0, 7, 99, 1'b1, 1'b0, 1'b0));
    tick();
    beat(0, 128'h8000_0000, 0, 1, 6, 0);
    tick();
    beat(0, 128'h1234_5678, 3, 3, 77, 'h55);
    tick();
    check("term.stage", obs[0][3], 128'd0);
    check("term.loc", obs[0][4], 128'd0);
    tick();
    check("pass.stage", obs[0][3], 128'd3);
    check("pass.loc", obs[0][4], 128'd77);
    check("pass.result", obs[0][5], 128'h55);

    // Write and read of node@7 in the same cycle, then 8 back-to-back beats.
    wr(0, 7, mk(128'hC000_0000, 2, 9, 200, 1'b1, 1'b1, 1'b1));
    beat(0, 128'hC000_0001, 1, 1, 7, 0);
    tick(); tick();
    check("wfirst.loc", obs[0][4], 128'd201);
    check("wfirst.result", obs[0][5], 128'h807);
    for (int i = 0; i < 8; i++) begin
      int loc;
      loc = $urandom_range(0, 15);
      beat(0, mem_m[0][loc].prefix ^ (rnd_key(0) >> $urandom_range(0, 32)), $urandom_range(0, 31), 1, loc, i);
      tick();
    end
    tick();

    // 128-bit keys: exact full-length match, single-bit miss, zero-length match.
    p = rnd_key(1);
    wr(1, 3, mk(p, 128, 5, 100, 1'b1, 1'b1, 1'b1));
    tick();
    wr(1, 4, mk(rnd_key(1), 0, 6, 300, 1'b0, 1'b1, 1'b1));
    tick();
    beat(1, p, 0, 2, 3, 0);
    tick();
    beat(1, p ^ 128'd1, 0, 2, 3, 0);
    tick();
    check("v6_exact.result", obs[1][5], 128'h1003);
    beat(1, rnd_key(1), 5, 2, 4, 0);
    tick();
    check("v6_bit0.result", obs[1][5], 128'h0);
    tick();
    check("v6_len0.result", obs[1][5], 128'h1004);

    // Reset with two beats in flight; memory written before and during reset survives.
    wr(0, 9, mk(128'hAB00_0000, 8, 4, 12, 1'b1, 1'b1, 1'b1));
    tick();
    beat(0, 128'hAB00_0000, 0, 1, 9, 0);
    tick();
    beat(0, 128'hAB00_0000, 0, 1, 9, 0);
    tick();
    rst = 1'b1;
    wr(0, 10, mk(128'hCD00_0000, 8, 5, 13, 1'b1, 1'b1, 1'b1));
    tick();
    rst = 1'b0;
    check("rst.valid", obs[0][0], 128'd0);
    check("rst.hits", obs[0][6], 128'd0);
    beat(0, 128'hAB00_0000, 0, 1, 9, 0);
    tick();
    check("rst_drain.valid", obs[0][0], 128'd0);
    beat(0, 128'hCD00_0000, 0, 1, 10, 0);
    tick();
    check("after_rst.result", obs[0][5], 128'h809);
    tick();
    check("rst_write.result", obs[0][5], 128'h80A);

    // Randomized traffic with node updates and occasional resets.
    for (int it = 0; it < 500; it++) begin
      for (int d = 0; d < 2; d++) begin
        int kb;
        int loc;
        int st;
        int bp;
        kb = kbits(d);
        if ($urandom_range(0, 3) == 0) wr(d, $urandom_range(0, 15), rnd_node(d));
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 3))
            0, 1:    st = sid(d);
            2:       st = $urandom_range(0, 63);
            default: st = 0;
          endcase
          loc = (st == sid(d)) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2047));
          bp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (d == 0) ? 63 : 255))
                                            : int'($urandom_range(0, kb - 1));
          beat(d, mem_m[d][loc].prefix ^ (rnd_key(d) >> $urandom_range(0, kb)), bp, st, loc,
               $urandom_range(0, 131071));
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
      rst = 1'b0;
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
